// File: rtl/usr_shift_controller_pkg.sv
// Shared encodings for the universal shift register controller.
//   op_e    : command opcodes carried on cmd_op
//   mode_e  : {s1,s0} mode select driven into the register datapath
//   state_e : controller FSM states
package usr_shift_controller_pkg;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_SHIFT  = 2'b01,
    OP_ROTATE = 2'b10,
    OP_WAIT   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

endpackage

// File: rtl/usr_reg.sv
// WIDTH-bit universal shift register, one 4:1 mode mux per bit.
//   clk, reset  : clock, asynchronous active-high reset (q clears)
//   mode        : hold / shift right / shift left / parallel load
//   data        : parallel load word
//   fill_right  : bit entering at WIDTH-1 on a right shift
//   fill_left   : bit entering at bit 0 on a left shift
//   q           : register contents
module usr_reg
  import usr_shift_controller_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] data,
  input  logic             fill_right,
  input  logic             fill_left,
  output logic [WIDTH-1:0] q
);

  // Neighbour vectors extended by the fill bit so every bit's mux
  // reads an in-range source without edge special cases.
  logic [WIDTH:0]   from_above;
  logic [WIDTH:0]   from_below;
  logic [WIDTH-1:0] d;

  assign from_above = {fill_right, q};
  assign from_below = {q, fill_left};

  always_comb begin
    d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      unique case (mode)
        MODE_HOLD:  d[i] = q[i];
        MODE_RIGHT: d[i] = from_above[i+1];
        MODE_LEFT:  d[i] = from_below[i];
        MODE_LOAD:  d[i] = data[i];
        default:    d[i] = q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/usr_shift_controller.sv
// Command-driven controller for a universal shift register.
//   clk, reset           : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake, accepted only in IDLE
//   cmd_op, cmd_dir      : LOAD/SHIFT/ROTATE/WAIT, 0=right 1=left
//   cmd_count, cmd_data  : cycle count, parallel load word
//   serial_in            : fill bit for SHIFT
//   s0, s1               : register mode select
//   q, serial_out        : register contents, exiting bit for latched dir
//   busy, done           : not-IDLE flag, one-cycle completion pulse
module usr_shift_controller
  import usr_shift_controller_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             serial_in,
  output logic             s0,
  output logic             s1,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  state_e           state, state_nxt;
  op_e              op_r;
  logic             dir_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] cnt_r;
  mode_e            mode;
  logic             accept;
  logic             fill_right, fill_left;

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (accept) begin
          if (op_e'(cmd_op) != OP_LOAD && cmd_count == '0) state_nxt = ST_DONE;
          else                                             state_nxt = ST_EXEC;
        end
      // LOAD always takes a single EXEC cycle regardless of the count field.
      ST_EXEC: if (op_r == OP_LOAD || cnt_r <= CNT_W'(1)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r   <= OP_LOAD;
      dir_r  <= 1'b0;
      data_r <= '0;
      cnt_r  <= '0;
    end else if (accept) begin
      op_r   <= op_e'(cmd_op);
      dir_r  <= cmd_dir;
      data_r <= cmd_data;
      cnt_r  <= cmd_count;
    end else if (state == ST_EXEC && cnt_r != '0) begin
      cnt_r  <= cnt_r - CNT_W'(1);
    end
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE) && !reset;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    mode      = MODE_HOLD;
    if (state == ST_EXEC) begin
      unique case (op_r)
        OP_LOAD:             mode = MODE_LOAD;
        OP_SHIFT, OP_ROTATE: mode = dir_r ? MODE_LEFT : MODE_RIGHT;
        OP_WAIT:             mode = MODE_HOLD;
        default:             mode = MODE_HOLD;
      endcase
    end
  end

  assign {s1, s0} = mode;

  // Rotate recirculates the bit leaving the opposite end.
  assign fill_right = (op_r == OP_ROTATE) ? q[0]       : serial_in;
  assign fill_left  = (op_r == OP_ROTATE) ? q[WIDTH-1] : serial_in;
  assign serial_out = dir_r ? q[WIDTH-1] : q[0];

  usr_reg #(
    .WIDTH(WIDTH)
  ) u_reg (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .data      (data_r),
    .fill_right(fill_right),
    .fill_left (fill_left),
    .q         (q)
  );

endmodule

// File: tb/tb_usr_shift_controller.sv
// Self-checking bench for usr_shift_controller (WIDTH=8, CNT_W=4).
module tb_usr_shift_controller;

  localparam int W = 8;
  localparam logic [1:0] LOAD = 2'd0, SHIFT = 2'd1, ROT = 2'd2, WAITOP = 2'd3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = '0;
  logic         cmd_dir = 1'b0;
  logic [3:0]   cmd_count = '0;
  logic [W-1:0] cmd_data = '0;
  logic         serial_in = 1'b0;
  logic         s0, s1, serial_out, busy, done;
  logic [W-1:0] q;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  usr_shift_controller #(.WIDTH(W), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_count(cmd_count), .cmd_data(cmd_data),
    .serial_in(serial_in), .s0(s0), .s1(s1), .q(q), .serial_out(serial_out),
    .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: an accepted command becomes a list of pending
  // cycles (n EXEC steps then one DONE); each clock edge retires one.
  typedef struct { bit exec; } step_t;
  step_t        sched[$];
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_data = '0;
  logic [1:0]   m_op = '0;
  logic         m_dir = 1'b0;

  always @(posedge clk or posedge reset) begin
    step_t st;
    int n;
    if (reset) begin
      sched.delete();
      m_q = '0;
      m_dir = 1'b0;
    end else if (sched.size() == 0) begin
      if (cmd_valid) begin
        m_op = cmd_op; m_dir = cmd_dir; m_data = cmd_data;
        n = (cmd_op == LOAD) ? 1 : int'(cmd_count);
        for (int i = 0; i < n; i++) sched.push_back('{exec: 1'b1});
        sched.push_back('{exec: 1'b0});
      end
    end else begin
      st = sched.pop_front();
      if (st.exec) begin
        case (m_op)
          LOAD:  m_q = m_data;
          SHIFT: m_q = m_dir ? ((m_q << 1) | W'(serial_in))
                             : ((m_q >> 1) | (W'(serial_in) << (W - 1)));
          ROT:   m_q = m_dir ? ((m_q << 1) | (m_q >> (W - 1)))
                             : ((m_q >> 1) | (m_q << (W - 1)));
          default: ;
        endcase
      end
    end
  end

  function automatic logic [1:0] mode_of(input logic [1:0] op, input logic dir);
    if (op == LOAD) return 2'b11;
    if (op == WAITOP) return 2'b00;
    return dir ? 2'b10 : 2'b01;
  endfunction

  always @(negedge clk) begin
    bit idle;
    idle = (sched.size() == 0);
    check("cmd_ready", 32'(cmd_ready), 32'(idle && !reset));
    check("busy", 32'(busy), 32'(!idle));
    check("done", 32'(done), 32'(!idle && !sched[0].exec));
    check("mode", 32'({s1, s0}), 32'((!idle && sched[0].exec) ? mode_of(m_op, m_dir) : 2'b00));
    check("q", 32'(q), 32'(m_q));
    check("serial_out", 32'(serial_out), 32'(m_dir ? m_q[W-1] : m_q[0]));
  end

  // Issue one command from IDLE; bc returns how many cycles busy was high.
  // With hold set, cmd_valid stays high with junk LOAD commands while busy.
  task automatic run_cmd(input logic [1:0] op, input logic dir, input logic [3:0] cnt,
                         input logic [W-1:0] data, input logic sin, input bit hold,
                         output int bc);
    @(negedge clk);
    #1 cmd_valid = 1'b1; cmd_op = op; cmd_dir = dir; cmd_count = cnt;
    cmd_data = data; serial_in = sin;
    @(negedge clk);
    bc = 0;
    while (busy && bc < 40) begin
      bc++;
      #1;
      if (hold) begin
        cmd_op = LOAD; cmd_data = W'($urandom); cmd_dir = 1'($urandom); cmd_count = 4'($urandom);
      end else cmd_valid = 1'b0;
      @(negedge clk);
    end
    #1 cmd_valid = 1'b0;
    if (bc >= 40) check("busy_timeout", 32'(bc), 32'(0));
  endtask

  initial begin
    int bc;
    int cyc;
    int acc;
    int rec[2];
    repeat (2) @(negedge clk);
    check("rst_q", 32'(q), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ready", 32'(cmd_ready), 32'h0);
    check("rst_mode", 32'({s1, s0}), 32'h0);
    #1 reset = 1'b0;

    run_cmd(LOAD, 1'b0, 4'd7, 8'hA5, 1'b0, 0, bc);
    check("load_cycles", 32'(bc), 32'd2);
    check("load_q", 32'(q), 32'hA5);

    run_cmd(SHIFT, 1'b0, 4'd3, 8'h00, 1'b1, 0, bc);
    check("shr3_cycles", 32'(bc), 32'd4);
    check("shr3_q", 32'(q), 32'hF4);

    run_cmd(LOAD, 1'b0, 4'd0, 8'h81, 1'b0, 0, bc);
    run_cmd(ROT, 1'b1, 4'd9, 8'h00, 1'b0, 0, bc);
    check("rotl9_cycles", 32'(bc), 32'd10);
    check("rotl9_q", 32'(q), 32'h03);

    run_cmd(LOAD, 1'b0, 4'd0, 8'h81, 1'b0, 0, bc);
    run_cmd(ROT, 1'b0, 4'd8, 8'h00, 1'b1, 0, bc);
    check("rotr8_q", 32'(q), 32'h81);

    run_cmd(SHIFT, 1'b1, 4'd0, 8'hFF, 1'b1, 0, bc);
    check("cnt0_cycles", 32'(bc), 32'd1);
    check("cnt0_q", 32'(q), 32'h81);

    run_cmd(WAITOP, 1'b0, 4'd15, 8'h00, 1'b1, 1, bc);
    check("wait15_cycles", 32'(bc), 32'd16);
    check("wait15_q", 32'(q), 32'h81);

    run_cmd(ROT, 1'b1, 4'd15, 8'h00, 1'b0, 0, bc);
    check("rotl15_cycles", 32'(bc), 32'd16);
    check("rotl15_q", 32'(q), 32'hC0);

    // Reset during the second EXEC cycle of SHIFT right count 5.
    run_cmd(LOAD, 1'b0, 4'd0, 8'hFF, 1'b0, 0, bc);
    @(negedge clk);
    #1 cmd_valid = 1'b1; cmd_op = SHIFT; cmd_dir = 1'b0; cmd_count = 4'd5; serial_in = 1'b0;
    @(negedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_q", 32'(q), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    run_cmd(LOAD, 1'b0, 4'd3, 8'h3C, 1'b0, 0, bc);
    check("post_rst_cycles", 32'(bc), 32'd2);
    check("post_rst_q", 32'(q), 32'h3C);

    // Back-to-back SHIFT left 2 with cmd_valid held and cmd_data churning.
    acc = 0; cyc = 0; rec[0] = 0; rec[1] = 0;
    cmd_op = SHIFT; cmd_dir = 1'b1; cmd_count = 4'd2; serial_in = 1'b0;
    while (cyc < 30) begin
      @(negedge clk);
      if (acc == 2) begin
        #1 cmd_valid = 1'b0;
        break;
      end
      if (cmd_ready && acc < 2) begin
        rec[acc] = cyc;
        acc++;
      end
      #1 cmd_valid = 1'b1; cmd_data = W'($urandom);
      cyc++;
    end
    cmd_valid = 1'b0;
    check("b2b_accepts", 32'(acc), 32'd2);
    check("b2b_spacing", 32'(rec[1] - rec[0]), 32'd4);
    cyc = 0;
    while (!cmd_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 40) check("idle_timeout", 32'(cyc), 32'd0);
    check("b2b_q", 32'(q), 32'hC0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/usr_shift_controller.md
USR_SHIFT_CONTROLLER -- requirements
Module: usr_shift_controller

Interface
REQ-001 Parameter WIDTH, 8, register width in bits (>=2).
REQ-002 Parameter CNT_W, 4, width of the shift-count field.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_op  input  2  00 LOAD, 01 SHIFT (fill from serial_in), 10 ROTATE, 11 WAIT (hold for count cycles).
REQ-008 cmd_dir  input  1  0 = right (toward bit 0), 1 = left (toward bit WIDTH-1).
REQ-009 cmd_count  input  CNT_W  number of shift/wait cycles.
REQ-010 cmd_data  input  WIDTH  parallel word for LOAD.
REQ-011 serial_in  input  1  fill bit for SHIFT.
REQ-012 s0, s1  output  1 each  register mode select: {s1,s0} 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-013 q  output  WIDTH  register contents.
REQ-014 serial_out  output  1  q[0] when latched dir = 0, else q[WIDTH-1].
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, EXEC and DONE.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid && cmd_ready.
REQ-019 On accept, op, dir, data and count SHALL be latched, and command inputs SHALL be ignored until the next IDLE.
REQ-020 On accept of LOAD, the FSM SHALL enter EXEC for exactly 1 cycle with {s1,s0}=11, so q = cmd_data after that edge.
REQ-021 On accept of SHIFT, ROTATE or WAIT with count n>=1, the FSM SHALL enter EXEC for exactly n cycles and decrement the remaining count each edge.
REQ-022 On accept with count 0 of any non-LOAD op, the FSM SHALL go directly to DONE and q SHALL be unchanged.
REQ-023 In SHIFT right, each EXEC edge SHALL set q <= {serial_in, q[WIDTH-1:1]}; in SHIFT left, q <= {q[WIDTH-2:0], serial_in}.
REQ-024 ROTATE SHALL feed the exiting bit back: right feeds q[0] into bit WIDTH-1, left feeds q[WIDTH-1] into bit 0.
REQ-025 WAIT SHALL drive {s1,s0}=00 for n EXEC cycles.
REQ-026 In IDLE and DONE, {s1,s0} SHALL be 00 and q SHALL hold.
REQ-027 After the last EXEC cycle, the FSM SHALL enter DONE for exactly 1 cycle with done=1, then return to IDLE.
REQ-028 Command to command, throughput SHALL be 1 (accept) + max(n,1 for LOAD else 0) + 1 (DONE) cycles; back-to-back commands are accepted on the first IDLE cycle.
REQ-029 A count of 2^CNT_W-1 SHALL be honoured without wrap; the count SHALL never underflow.
REQ-030 s0, s1, busy, done and cmd_ready SHALL be decoded from registered state only, with no combinational path from cmd_* inputs.

Reset
REQ-031 While reset is high, the block SHALL hold state IDLE, q=0, remaining count 0, latched dir 0, done=0, busy=0, {s1,s0}=00; cmd_ready becomes 1 once reset deasserts.
REQ-032 A reset asserted mid-EXEC SHALL abort the command immediately with no done pulse, and the first command after release SHALL behave as if no command had preceded it.

Structure
REQ-033 A shared package SHALL hold the op encodings, the mode-select encodings and the FSM state type.
REQ-034 The register datapath SHALL be a sub-module usr_reg (WIDTH-bit universal shift register with per-bit 4:1 mode select); the controller SHALL contain the FSM and counter.

Verification
REQ-035 Reset, then LOAD 0xA5 -> one EXEC cycle with {s1,s0}=11, q=0xA5, done pulse on the next cycle, cmd_ready back high.
REQ-036 From q=0xA5, SHIFT right, count 3, serial_in=1 -> exactly 3 shift-right cycles, q=0xF4, one done pulse.
REQ-037 From q=0x81, ROTATE left, count 9 (WIDTH=8) -> q=0x03; ROTATE right, count 8 from 0x81 -> q=0x81.
REQ-038 SHIFT, count 0 -> DONE on the cycle after accept, q unchanged, no nonzero mode select.
REQ-039 Assert reset during cycle 2 of a SHIFT count 5 -> q=0 immediately, no done pulse, next LOAD 0x3C behaves normally.
REQ-040 Hold cmd_valid high with changing cmd_data while busy -> no effect on q; commands are accepted only in IDLE, and back-to-back accept timing matches REQ-028.
